// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: host command and program-load byte stream handshakes
interface cpu_run_controller_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] cmd_data;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_byte;
    logic       load_last;
    modport master (output cmd_valid, cmd, cmd_data, load_valid, load_byte, load_last,
                    input  cmd_ready, load_ready);
    modport slave  (input  cmd_valid, cmd, cmd_data, load_valid, load_byte, load_last,
                    output cmd_ready, load_ready);
endinterface

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: loads program memory and sequences CPU reset, run, step and halt
module cpu_run_controller #(
    parameter int          RESET_CYCLES = 2,
    parameter logic [15:0] MAX_CYCLES   = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_run_controller_if.slave   host,
    output logic                  mem_we,
    output logic [7:0]            mem_waddr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  cpu_en,
    input  logic                  cpu_halt,
    input  logic [7:0]            cpu_pc,
    input  logic                  bp_en,
    input  logic [7:0]            bp_addr,
    output logic [2:0]            state,
    output logic [2:0]            halt_reason,
    output logic [15:0]           cycle_count,
    output logic                  load_overflow
);
    typedef enum logic [2:0] {IDLE, LOAD, RESET, RUN, STEP, HALTED} state_t;
    localparam logic [1:0] C_LOAD = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_STOP = 2'd3;
    state_t      st;
    logic [15:0] rcnt;
    logic [7:0]  ptr, lo;
    logic        odd, resumed;
    logic        cmd_acc, load_acc, bp_hit, stop_cmd, wd, stop;
    assign state           = st;
    assign host.cmd_ready  = st == IDLE || st == HALTED || st == RUN;
    assign host.load_ready = st == LOAD;
    assign cpu_rst         = st == IDLE || st == LOAD || st == RESET;
    assign cmd_acc         = host.cmd_valid & host.cmd_ready;
    assign load_acc        = host.load_valid & host.load_ready;
    // The first cycle after a resume ignores the breakpoint so the CPU can step off it
    assign bp_hit          = bp_en && cpu_pc == bp_addr && !resumed;
    assign stop_cmd        = cmd_acc && host.cmd == C_STOP;
    assign wd              = cycle_count == MAX_CYCLES;
    assign stop            = cpu_halt | bp_hit | stop_cmd | wd;
    assign cpu_en          = (st == RUN && !stop) || st == STEP;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            mem_we        <= 1'b0;
            mem_waddr     <= '0;
            mem_wdata     <= '0;
            halt_reason   <= '0;
            cycle_count   <= '0;
            load_overflow <= 1'b0;
            rcnt          <= '0;
            ptr           <= '0;
            lo            <= '0;
            odd           <= 1'b0;
            resumed       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (cpu_en && !wd) cycle_count <= cycle_count + 16'd1;
            case (st)
                IDLE, HALTED: if (cmd_acc) begin
                    if (host.cmd == C_LOAD) begin
                        st            <= LOAD;
                        ptr           <= host.cmd_data;
                        load_overflow <= 1'b0;
                        odd           <= 1'b0;
                    end else if (host.cmd == C_RUN && (st == IDLE || !host.cmd_data[0])) begin
                        st          <= RESET;
                        rcnt        <= '0;
                        cycle_count <= '0;
                        halt_reason <= '0;
                    end else if (host.cmd == C_RUN) begin
                        st          <= RUN;
                        halt_reason <= '0;
                        resumed     <= 1'b1;
                    end else if (host.cmd == C_STEP && st == HALTED && !cpu_halt) begin
                        st <= STEP;
                    end
                end
                LOAD: if (load_acc) begin
                    if (odd || host.load_last) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= ptr;
                        mem_wdata <= odd ? {host.load_byte, lo} : {8'h00, host.load_byte};
                        ptr       <= ptr + 8'd1;
                        if (ptr == 8'hFF) load_overflow <= 1'b1;
                    end else begin
                        lo <= host.load_byte;
                    end
                    odd <= !odd;
                    if (host.load_last) st <= IDLE;
                end
                RESET: if (rcnt == 16'(RESET_CYCLES - 1)) st <= RUN; else rcnt <= rcnt + 16'd1;
                RUN: begin
                    resumed <= 1'b0;
                    if (stop) begin
                        st          <= HALTED;
                        halt_reason <= cpu_halt ? 3'd1 : bp_hit ? 3'd2 : stop_cmd ? 3'd3 : 3'd4;
                    end
                end
                STEP: begin
                    st          <= HALTED;
                    halt_reason <= 3'd5;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Host-facing sequencer for the 8-bit CPU core and its 256x16 program memory.
- Loads program words into memory from a byte stream, holds the CPU in reset while idle or loading, and releases it for free-run, resume or single-step.
- Stops the CPU on core halt, breakpoint, host STOP or watchdog expiry, and reports why.
- Sits between the host/debug port and the CPU core, the memory write port and the CPU clock-enable.

Parameters:
- RESET_CYCLES, 2, number of cycles cpu_rst is held before a reset-run; must be at least 1.
- MAX_CYCLES, 16'hFFFF, watchdog limit on executed CPU cycles per run.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd  in  2  command: 0 LOAD, 1 RUN, 2 STEP, 3 STOP.
- cmd_data  in  8  LOAD: base address; RUN: bit0=1 resumes without reset.
- load_valid  in  1  load byte valid.
- load_ready  out  1  load byte accepted.
- load_byte  in  8  program byte; low byte of each word first.
- load_last  in  1  marks the final byte of the stream.
- mem_we  out  1  program memory write strobe.
- mem_waddr  out  8  write address.
- mem_wdata  out  16  write data.
- cpu_rst  out  1  CPU synchronous reset.
- cpu_en  out  1  CPU clock-enable; the CPU advances one instruction per cycle in which it is high.
- cpu_halt  in  1  CPU halt flag.
- cpu_pc  in  8  CPU program counter.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  8  breakpoint PC.
- state  out  3  0 IDLE, 1 LOAD, 2 RESET, 3 RUN, 4 STEP, 5 HALTED.
- halt_reason  out  3  0 none, 1 cpu_halt, 2 breakpoint, 3 STOP, 4 timeout, 5 step done.
- cycle_count  out  16  CPU cycles executed since the last reset-run.
- load_overflow  out  1  sticky: a load write wrapped past address 255.

Behaviour:
- Async reset (rst_n low) forces:
  - state=IDLE, cpu_rst=1, cpu_en=0, mem_we=0, mem_waddr=0, mem_wdata=0;
  - halt_reason=0, cycle_count=0, load_overflow=0, internal reset counter=0.
- Reset may assert mid-LOAD or mid-RUN: partial words are discarded and no write completes.
- cpu_rst=1 in IDLE, LOAD and RESET; 0 in RUN, STEP and HALTED.
- cmd_ready=1 in IDLE, HALTED and RUN; 0 in LOAD, RESET and STEP.
- In RUN, only STOP acts; any other accepted command is dropped.
- In IDLE/HALTED, STOP is accepted with no effect. STEP in IDLE is accepted and ignored.
- LOAD (IDLE/HALTED):
  - Entry: address ptr=cmd_data, load_overflow cleared, state=LOAD.
  - load_ready=1 only in LOAD; one byte per handshake.
  - Even-position byte is latched as word[7:0]. Odd-position byte forms word[15:8], and the word is written the next cycle: mem_we=1 for exactly 1 cycle, mem_waddr=ptr, then ptr=ptr+1 mod 256.
  - If ptr wraps 255->0 on a write, load_overflow=1.
  - If load_last arrives on an even-position byte, that word is written with high byte 0.
  - After the final write, state=IDLE with mem_we low in the following cycle.
- RUN, reset path (cmd_data[0]=0, or any RUN from IDLE):
  - state=RESET; cpu_rst held exactly RESET_CYCLES cycles.
  - cycle_count=0, halt_reason=0; then state=RUN.
- RUN, resume path (from HALTED with cmd_data[0]=1): state=RUN directly, cycle_count retained, halt_reason=0.
- Stop-condition evaluation in RUN, each cycle, in priority order:
  - stop = cpu_halt | bp_hit | STOP accepted | cycle_count==MAX_CYCLES.
  - bp_hit = bp_en & cpu_pc==bp_addr, masked on the first RUN cycle after resume so execution can leave the breakpoint.
- cpu_en is combinational: (state==RUN & !stop) | (state==STEP).
- On stop: state=HALTED next cycle; halt_reason set to the highest-priority cause, in order 1,2,3,4.
- cycle_count increments on every cycle with cpu_en=1 and saturates at MAX_CYCLES.
- STEP (HALTED only, and only if cpu_halt=0):
  - state=STEP for exactly 1 cycle with cpu_en=1, cycle_count+1, then HALTED with halt_reason=5.
  - If cpu_halt=1, STEP is accepted and ignored.
- HALTED: cpu_en=0, CPU state frozen (cpu_rst=0). Breakpoint and watchdog are not evaluated.

Test Plan:
- Reset mid-LOAD after 3 bytes -> state=IDLE, cpu_rst=1, no further mem_we, load_overflow=0.
- LOAD base=8'hFE, bytes 01 02 03 04 05 (last on 05) -> writes FE:0201, FF:0403, 00:0005; load_overflow=1; state returns to IDLE.
- RUN with cmd_data=0, RESET_CYCLES=2 -> cpu_rst high for 2 cycles, then cpu_en=1. cpu_halt rises after 10 enabled cycles -> HALTED, halt_reason=1, cycle_count=10.
- bp_en=1, bp_addr=8'h06 during RUN -> cpu_en low in the cycle cpu_pc=06, halt_reason=2. Then RUN with cmd_data[0]=1 -> PC leaves 06 with no immediate re-halt.
- From HALTED: STEP x3 -> exactly 3 single-cycle cpu_en pulses, cycle_count +3, halt_reason=5, cmd_ready=0 during each STEP cycle.
- MAX_CYCLES=20, program with no halt -> HALTED with halt_reason=4, cycle_count=20. STOP issued during RUN with cpu_halt rising the same cycle -> halt_reason=1.
